// File: rtl/halfband_pkg.sv
// Shared halfband constants: coefficient sets, centre tap and latency helpers
// for the interpolator stages and the blocks that instantiate them.
package halfband_pkg;

    localparam int HB_COEF_W = 18;
    localparam int HB_NUM_NZ = 4;

    // h[0] (outermost tap) sits in the least significant slice.
    localparam logic [HB_NUM_NZ*HB_COEF_W-1:0] HB1_COEFS =
        {18'sd78535, -18'sd15925, 18'sd3274, -18'sd348};
    localparam logic [HB_NUM_NZ*HB_COEF_W-1:0] HB2_COEFS =
        {18'sd78408, -18'sd15695, 18'sd3144, -18'sd322};

    localparam int HB_CENTER = 131071;

    // Input-to-phase-A latency of one stage.
    function automatic int hb_lat(input int num_nz);
        return 4 + $clog2(num_nz);
    endfunction

    // Number of nodes left after l pairwise reduction levels of n elements.
    function automatic int hb_cnt(input int n, input int l);
        return (n + (1 << l) - 1) >> l;
    endfunction

endpackage

// File: rtl/halfband_interp2_if.sv
// Sample-stream bundle of one interpolator stage: strobed input sample and
// strobed, phase-tagged output sample plus the sticky drop flag.
interface halfband_interp2_if #(
    parameter int DATA_W = 18
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] x_in;
    logic                     out_valid;
    logic                     out_phase;
    logic signed [DATA_W-1:0] y;
    logic                     overrun;

    modport master (
        output in_valid, x_in,
        input  out_valid, out_phase, y, overrun
    );

    modport slave (
        input  in_valid, x_in,
        output out_valid, out_phase, y, overrun
    );
endinterface

// File: rtl/hb_adder_tree.sv
// Registered pairwise adder tree: N signed inputs, $clog2(N) register levels,
// an odd trailing element is carried through its level with a register. N >= 2.
module hb_adder_tree
    import halfband_pkg::*;
#(
    parameter int N    = 4,
    parameter int W_IN = 37
) (
    input  logic                                 sys_clk,
    input  logic                                 reset,
    input  logic                                 vld_in,
    input  logic signed [W_IN-1:0]               din [N],
    output logic                                 vld_out,
    output logic signed [W_IN+$clog2(N)-1:0]     dout
);

    localparam int LVL   = $clog2(N);
    localparam int W_OUT = W_IN + LVL;

    for (genvar l = 0; l < LVL; l++) begin : lvl_g
        localparam int CIN  = hb_cnt(N, l);
        localparam int COUT = hb_cnt(N, l + 1);

        logic signed [W_OUT-1:0] src_s  [2*COUT];
        logic signed [W_OUT-1:0] node_r [COUT];
        logic                    vsrc_s;
        logic                    vld_r;

        for (genvar i = 0; i < 2*COUT; i++) begin : src_g
            if (i >= CIN) begin : pad_g
                assign src_s[i] = '0;
            end else if (l == 0) begin : in_g
                assign src_s[i] = W_OUT'(din[i]);
            end else begin : up_g
                assign src_s[i] = lvl_g[l-1].node_r[i];
            end
        end

        if (l == 0) begin : vin_g
            assign vsrc_s = vld_in;
        end else begin : vup_g
            assign vsrc_s = lvl_g[l-1].vld_r;
        end

        // One reduction level; a padded zero partner turns the odd node into a pass-through.
        always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
                vld_r <= 1'b0;
                for (int i = 0; i < COUT; i++) node_r[i] <= '0;
            end else begin
                vld_r <= vsrc_s;
                for (int i = 0; i < COUT; i++) node_r[i] <= src_s[2*i] + src_s[2*i+1];
            end
        end
    end

    assign dout    = lvl_g[LVL-1].node_r[0];
    assign vld_out = lvl_g[LVL-1].vld_r;

endmodule

// File: rtl/halfband_interp2.sv
// halfband_interp2: 2x polyphase halfband interpolator, each input yields phase A then phase B.
// Build option HB_INTERP_SAT_EN: saturate scaled results to DATA_W bits instead of wrapping.
module halfband_interp2
    import halfband_pkg::*;
#(
    parameter int                       DATA_W = 18,
    parameter int                       COEF_W = 18,
    parameter int                       NUM_NZ = 4,
    parameter logic [NUM_NZ*COEF_W-1:0] COEFS  = HB1_COEFS,
    parameter int                       CENTER = HB_CENTER
) (
    input logic                sys_clk,
    input logic                reset,
    halfband_interp2_if.slave  bus
);

    localparam int TAPS   = 2 * NUM_NZ;
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int LVL    = $clog2(NUM_NZ);
    localparam int SUM_W  = PROD_W + LVL;
    localparam int SHIFT  = COEF_W - 1;
    localparam logic signed [COEF_W-1:0] CEN_C = COEF_W'(CENTER);

    logic signed [COEF_W-1:0] coef_s [NUM_NZ];
    logic                     accept_s;
    logic                     drop_s;
    logic                     acc_prev_r;
    logic                     overrun_r;
    logic signed [DATA_W-1:0] dly_r [TAPS];
    logic                     v1_r, v2_r, v3_r;
    logic signed [PRE_W-1:0]  pre_r [NUM_NZ];
    logic signed [PROD_W-1:0] prod_r [NUM_NZ];
    logic signed [DATA_W-1:0] cen_d_r;
    logic signed [PROD_W-1:0] cen_prod_r;
    logic signed [SUM_W-1:0]  cen_pipe_r [LVL];
    logic signed [SUM_W-1:0]  sum_s;
    logic                     sum_vld_s;
    logic signed [DATA_W-1:0] y_r;
    logic                     out_valid_r;
    logic                     out_phase_r;
    logic                     pend_r;
    logic signed [DATA_W-1:0] pend_y_r;

    for (genvar k = 0; k < NUM_NZ; k++) begin : coef_g
        assign coef_s[k] = COEFS[k*COEF_W +: COEF_W];
    end

    // Gain-2 scaling (floor) and reduction of a full-precision result to DATA_W bits.
    function automatic logic signed [DATA_W-1:0] scale_reduce(input logic signed [SUM_W-1:0] v);
`ifdef HB_INTERP_SAT_EN
        localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
        localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};
        if ((v >>> SHIFT) > SUM_W'(Y_MAX)) begin
            return Y_MAX;
        end else if ((v >>> SHIFT) < SUM_W'(Y_MIN)) begin
            return Y_MIN;
        end else begin
            return DATA_W'(v >>> SHIFT);
        end
`else
        return DATA_W'(v >>> SHIFT);
`endif
    endfunction

    // A strobe directly after an accepted one cannot be serialised in time and is dropped.
    always_comb begin
        accept_s = bus.in_valid & ~acc_prev_r;
        drop_s   = bus.in_valid &  acc_prev_r;
    end

    // Acceptance history, sticky overrun and the sample delay line (d[0] newest).
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            acc_prev_r <= 1'b0;
            overrun_r  <= 1'b0;
            v1_r       <= 1'b0;
            for (int i = 0; i < TAPS; i++) dly_r[i] <= '0;
        end else begin
            acc_prev_r <= accept_s;
            overrun_r  <= overrun_r | drop_s;
            v1_r       <= accept_s;
            if (accept_s) begin
                dly_r[0] <= bus.x_in;
                for (int i = 1; i < TAPS; i++) dly_r[i] <= dly_r[i-1];
            end
        end
    end

    // Symmetric pre-add, multiply, and the centre-tap path delayed to meet the tree output.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            v2_r       <= 1'b0;
            v3_r       <= 1'b0;
            cen_d_r    <= '0;
            cen_prod_r <= '0;
            for (int k = 0; k < NUM_NZ; k++) begin
                pre_r[k]  <= '0;
                prod_r[k] <= '0;
            end
            for (int i = 0; i < LVL; i++) cen_pipe_r[i] <= '0;
        end else begin
            v2_r <= v1_r;
            v3_r <= v2_r;
            for (int k = 0; k < NUM_NZ; k++) begin
                pre_r[k]  <= PRE_W'(dly_r[k]) + PRE_W'(dly_r[TAPS-1-k]);
                prod_r[k] <= PROD_W'(pre_r[k]) * PROD_W'(coef_s[k]);
            end
            cen_d_r       <= dly_r[NUM_NZ-1];
            cen_prod_r    <= PROD_W'(cen_d_r) * PROD_W'(CEN_C);
            cen_pipe_r[0] <= SUM_W'(cen_prod_r);
            for (int i = 1; i < LVL; i++) cen_pipe_r[i] <= cen_pipe_r[i-1];
        end
    end

    hb_adder_tree #(
        .N    (NUM_NZ),
        .W_IN (PROD_W)
    ) u_tree (
        .sys_clk (sys_clk),
        .reset   (reset),
        .vld_in  (v3_r),
        .din     (prod_r),
        .vld_out (sum_vld_s),
        .dout    (sum_s)
    );

    // Serialiser: phase A when the tree result lands, the held phase B on the next cycle.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            y_r         <= '0;
            out_valid_r <= 1'b0;
            out_phase_r <= 1'b0;
            pend_r      <= 1'b0;
            pend_y_r    <= '0;
        end else if (sum_vld_s) begin
            y_r         <= scale_reduce(sum_s);
            out_valid_r <= 1'b1;
            out_phase_r <= 1'b0;
            pend_r      <= 1'b1;
            pend_y_r    <= scale_reduce(cen_pipe_r[LVL-1]);
        end else if (pend_r) begin
            y_r         <= pend_y_r;
            out_valid_r <= 1'b1;
            out_phase_r <= 1'b1;
            pend_r      <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.y         = y_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_phase = out_phase_r;
    assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_halfband_interp2.sv
// Scoreboard bench for halfband_interp2: a default-coefficient instance and a
// {0,0,0,131071} instance share stimulus and are checked against an arithmetic model.
module tb_halfband_interp2;
    import halfband_pkg::*;

    localparam int DW  = 18;
    localparam int LAT = hb_lat(4);

    typedef struct {
        int y;
        bit ph;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q_def[$];
    exp_t q_sat[$];
    int   hist [8];
    bit   prev_acc;
    bit   ov_exp;
    int   h_def [4] = '{-348, 3274, -15925, 78535};
    int   h_sat [4] = '{0, 0, 0, 131071};

    halfband_interp2_if #(.DATA_W(DW)) bif ();
    halfband_interp2_if #(.DATA_W(DW)) sif ();

    halfband_interp2 dut (
        .sys_clk (clk),
        .reset   (rst),
        .bus     (bif)
    );

    halfband_interp2 #(
        .COEFS ({18'sd131071, 18'sd0, 18'sd0, 18'sd0})
    ) dut_sat (
        .sys_clk (clk),
        .reset   (rst),
        .bus     (sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int reduce(input longint v);
`ifdef HB_INTERP_SAT_EN
        if (v > 64'sd131071) return 131071;
        else if (v < -64'sd131072) return -131072;
        else return int'(v);
`else
        longint w;
        w = v & 64'sh3FFFF;
        return (w >= 64'sd131072) ? int'(w - 64'sd262144) : int'(w);
`endif
    endfunction

    // Phase A: sum_k h[k]*(d[k]+d[7-k]), doubled gain via /2^17 with floor.
    function automatic int model_a(input int h [4], input int d [8]);
        longint acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(h[k]) * (longint'(d[k]) + longint'(d[7-k]));
        return reduce(acc >>> 17);
    endfunction

    function automatic int model_b(input int d [8]);
        return reduce((longint'(131071) * longint'(d[3])) >>> 17);
    endfunction

    task automatic accept(input int x, input int t);
        exp_t e;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
        e = '{model_a(h_def, hist), 1'b0, t + LAT};     q_def.push_back(e);
        e = '{model_b(hist),        1'b1, t + LAT + 1}; q_def.push_back(e);
        e = '{model_a(h_sat, hist), 1'b0, t + LAT};     q_sat.push_back(e);
        e = '{model_b(hist),        1'b1, t + LAT + 1}; q_sat.push_back(e);
    endtask

    task automatic send(input bit v, input int x);
        bif.in_valid = v;
        sif.in_valid = v;
        bif.x_in     = DW'(x);
        sif.x_in     = DW'(x);
        if (v && !prev_acc) begin
            accept(x, cyc);
            prev_acc = 1'b1;
        end else begin
            if (v) ov_exp = 1'b1;
            prev_acc = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0);
    endtask

    function automatic int rnd();
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    task automatic mon(input string tag, ref exp_t q[$], input logic vld, input logic ph,
                       input logic signed [DW-1:0] y);
        exp_t e;
        if (vld) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s.unexpected: got output y=%0d, want no output (cycle %0d)", tag, y, cyc);
            end else begin
                e = q.pop_front();
                check({tag, ".y"}, y, e.y);
                check({tag, ".phase"}, ph, e.ph);
                check({tag, ".cycle"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon("def", q_def, bif.out_valid, bif.out_phase, bif.y);
            mon("sat", q_sat, sif.out_valid, sif.out_phase, sif.y);
        end
    end

    initial begin
        bif.in_valid = 1'b0; bif.x_in = '0;
        sif.in_valid = 1'b0; sif.x_in = '0;
        prev_acc = 1'b0;
        ov_exp   = 1'b0;
        for (int i = 0; i < 8; i++) hist[i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset.y", bif.y, 0);
        check("reset.out_valid", bif.out_valid, 0);
        check("reset.out_phase", bif.out_phase, 0);
        check("reset.overrun", bif.overrun, 0);
        check("reset.sat_y", sif.y, 0);
        rst = 1'b0;
        idle(2);

        // impulse, one input every 2 cycles
        send(1'b1, 65536); send(1'b0, 0);
        repeat (7) begin send(1'b1, 0); send(1'b0, 0); end
        idle(10);

        // DC full-scale (also the saturation case on dut_sat)
        repeat (12) begin send(1'b1, 131071); send(1'b0, 0); end
        idle(10);

        // back-to-back at maximum rate
        repeat (50) begin send(1'b1, rnd()); send(1'b0, 0); end
        idle(10);

        // random gaps
        repeat (20) begin
            send(1'b1, rnd());
            repeat ($urandom_range(1, 3)) send(1'b0, 0);
        end
        idle(10);

        // overrun: second of two consecutive strobes is dropped
        check("overrun.before", bif.overrun, 0);
        send(1'b1, rnd()); send(1'b1, rnd());
        idle(12);
        check("overrun.set", bif.overrun, ov_exp);
        check("overrun.sat_set", sif.overrun, ov_exp);
        idle(20);
        check("overrun.sticky", bif.overrun, 1);

        // asynchronous mid-clock reset two cycles after an input
        send(1'b1, 70000); send(1'b0, 0); send(1'b0, 0);
        #3 rst = 1'b1;
        #1;
        check("midrst.y", bif.y, 0);
        check("midrst.out_valid", bif.out_valid, 0);
        check("midrst.overrun", bif.overrun, 0);
        check("midrst.sat_y", sif.y, 0);
        q_def.delete();
        q_sat.delete();
        prev_acc = 1'b0;
        ov_exp   = 1'b0;
        for (int i = 0; i < 8; i++) hist[i] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(12);
        send(1'b1, rnd()); send(1'b0, 0);
        idle(12);

        check("drain.def", q_def.size(), 0);
        check("drain.sat", q_sat.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
